// File: rtl/seg_display_ctrl_if.sv
// Bus between the processor output strobe and the segment display controller:
// bank write port, view/mode selection and the board segment pins.
interface seg_display_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int BANKS  = 8
);
  localparam int BANK_W = $clog2(BANKS);

  logic              wr_en;
  logic [BANK_W-1:0] wr_bank;
  logic [DATA_W-1:0] wr_val1;
  logic [DATA_W-1:0] wr_val2;
  logic [BANK_W-1:0] view_sel;
  logic              mode;
  logic [7:0]        seg_out;
  logic [7:0]        seg_sel;
  logic              conv_busy;

  modport master (
    output wr_en, wr_bank, wr_val1, wr_val2, view_sel, mode,
    input  seg_out, seg_sel, conv_busy
  );

  modport slave (
    input  wr_en, wr_bank, wr_val1, wr_val2, view_sel, mode,
    output seg_out, seg_sel, conv_busy
  );
endinterface

// File: rtl/seg_display_ctrl.sv
// Banked output latch driving an 8-digit multiplexed 7-segment display in hex or
// unsigned decimal; decimal digits come from a sequential double-dabble engine.
module seg_display_ctrl #(
  parameter int DATA_W     = 16,
  parameter int BANKS      = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clock,
  input  logic              reset,
  seg_display_ctrl_if.slave bus
);
  localparam int BANK_W = $clog2(BANKS);
  localparam int PRE_W  = $clog2(SCAN_DIV);
  localparam int CNT_W  = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } conv_state_e;

  logic [2*DATA_W-1:0] bank_q [BANKS];
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [2:0]          digit_q, digit_d;
  logic [BANK_W-1:0]   view_prev_q;
  logic                mode_prev_q;
  logic                trig_q, trig_d;
  conv_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [31:0]         bcd_q, bcd_d;
  logic [31:0]         result_q, result_d;
  logic [31:0]         bcd_adj;
  logic [7:0]          seg_out_q, seg_out_d;
  logic [7:0]          seg_sel_q, seg_sel_d;
  logic [2*DATA_W-1:0] view_word;
  logic [31:0]         hex_word;
  logic [3:0]          hex_nib;
  logic [3:0]          dec_nib;
  logic [7:0]          pattern;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  function automatic logic [7:0] polar(input logic [7:0] x);
    return (ACTIVE_LOW != 0) ? ~x : x;
  endfunction

  // Channels narrower than 16 bits are zero-extended; wider ones show only [15:0].
  function automatic logic [15:0] low16(input logic [DATA_W-1:0] v);
    logic [31:0] ext;
    ext = '0;
    ext[DATA_W-1:0] = v;
    return ext[15:0];
  endfunction

  function automatic logic [31:0] dabble_adj(input logic [31:0] b);
    logic [31:0] r;
    r = b;
    for (int i = 0; i < 8; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign bcd_adj = dabble_adj(bcd_q);

  // Digit scan: prescaler wrap advances the digit index
  always_comb begin
    pre_d   = pre_q + PRE_W'(1);
    digit_d = digit_q;
    if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      pre_d   = '0;
      digit_d = digit_q + 3'd1;
    end
  end

  assign trig_d = (bus.wr_en && (bus.wr_bank == bus.view_sel)) ||
                  (bus.view_sel != view_prev_q) ||
                  (bus.mode && !mode_prev_q);

  // Conversion engine: a pending trigger always reloads, so a superseded value never commits
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    bcd_d    = bcd_q;
    result_d = result_q;
    if (trig_q) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      sh_d    = bank_q[bus.view_sel][DATA_W-1:0];
      bcd_d   = '0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          bcd_d = {bcd_adj[30:0], sh_q[DATA_W-1]};
          sh_d  = sh_q << 1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_DONE;
        end
        ST_DONE: begin
          result_d = bcd_q;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Segment pattern for the digit that becomes active at this edge
  always_comb begin
    view_word = bank_q[bus.view_sel];
    hex_word  = {low16(view_word[2*DATA_W-1:DATA_W]), low16(view_word[DATA_W-1:0])};
    hex_nib   = hex_word[{digit_d, 2'b00} +: 4];
    dec_nib   = result_q[{digit_d, 2'b00} +: 4];
    pattern   = 8'h00;
    if (!bus.mode) begin
      pattern = {(digit_d == 3'd4), glyph(hex_nib)};
    end else if ((digit_d != 3'd0) && ((result_q >> {digit_d, 2'b00}) == 32'd0)) begin
      pattern = 8'h00;
    end else begin
      pattern = {1'b0, glyph(dec_nib)};
    end
    seg_out_d = polar(pattern);
    seg_sel_d = polar(8'h01 << digit_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < BANKS; i++) bank_q[i] <= '0;
      pre_q     <= '0;
      digit_q   <= '0;
      trig_q    <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      bcd_q     <= '0;
      result_q  <= '0;
      seg_out_q <= polar({1'b0, glyph(4'h0)});
      seg_sel_q <= polar(8'h01);
    end else begin
      if (bus.wr_en) bank_q[bus.wr_bank] <= {bus.wr_val2, bus.wr_val1};
      pre_q     <= pre_d;
      digit_q   <= digit_d;
      trig_q    <= trig_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      bcd_q     <= bcd_d;
      result_q  <= result_d;
      seg_out_q <= seg_out_d;
      seg_sel_q <= seg_sel_d;
    end
    // Tracked through reset so leaving reset never looks like a view or mode change
    view_prev_q <= bus.view_sel;
    mode_prev_q <= bus.mode;
  end

  assign bus.seg_out   = seg_out_q;
  assign bus.seg_sel   = seg_sel_q;
  assign bus.conv_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl: a behavioural model predicts each digit of a
// full scan; a monitor pops and compares whenever the active digit changes.
module tb_seg_display_ctrl;
  localparam int DATA_W     = 16;
  localparam int BANKS      = 8;
  localparam int SCAN_DIV   = 4;
  localparam int ACTIVE_LOW = 1;

  typedef struct {
    logic [7:0] sel;
    logic [7:0] seg;
    int         d;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  seg_display_ctrl_if #(.DATA_W(DATA_W), .BANKS(BANKS)) bus ();

  seg_display_ctrl #(
    .DATA_W(DATA_W), .BANKS(BANKS), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(ACTIVE_LOW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  logic [6:0]  GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [15:0] m_v1 [BANKS];
  logic [15:0] m_v2 [BANKS];
  int          m_view;
  bit          m_mode;
  int unsigned m_cnt = 0;
  exp_t        sb_q [$];
  int          vectors = 0;
  int          miscompares = 0;

  // Cycles since reset released; the active digit is (m_cnt / SCAN_DIV) mod 8
  always @(posedge clock) begin
    if (reset) m_cnt <= 0;
    else       m_cnt <= m_cnt + 1;
  end

  function automatic logic [7:0] exp_seg(int d);
    logic [7:0]  p;
    logic [31:0] w;
    logic [3:0]  nib;
    int unsigned v, pw;
    if (!m_mode) begin
      w   = {m_v2[m_view], m_v1[m_view]};
      nib = w[4*d +: 4];
      p   = {(d == 4), GLYPH[nib]};
    end else begin
      v  = m_v1[m_view];
      pw = 1;
      for (int k = 0; k < d; k++) pw = pw * 10;
      if (d > 0 && v < pw) p = 8'h00;
      else begin
        nib = 4'((v / pw) % 10);
        p   = {1'b0, GLYPH[nib]};
      end
    end
    return (ACTIVE_LOW != 0) ? ~p : p;
  endfunction

  function automatic logic [7:0] exp_sel(int d);
    logic [7:0] s;
    s = 8'h01 << d;
    return (ACTIVE_LOW != 0) ? ~s : s;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_now(string tag);
    int d;
    d = int'((m_cnt / SCAN_DIV) % 8);
    check({tag, "_sel"}, 32'(bus.seg_sel), 32'(exp_sel(d)));
    check({tag, "_seg"}, 32'(bus.seg_out), 32'(exp_seg(d)));
  endtask

  task automatic check_cycles(string tag, int n);
    repeat (n) begin
      @(negedge clock);
      check_now(tag);
    end
  endtask

  // Queue the expected pattern for the next eight digit changes and wait for the monitor
  task automatic arm_scan(string tag);
    exp_t e;
    int   d0, guard;
    while (m_cnt % SCAN_DIV == 0) @(negedge clock);
    d0 = int'((m_cnt / SCAN_DIV) % 8);
    for (int k = 1; k <= 8; k++) begin
      e.d   = (d0 + k) % 8;
      e.sel = exp_sel(e.d);
      e.seg = exp_seg(e.d);
      sb_q.push_back(e);
    end
    guard = 0;
    while (sb_q.size() > 0 && guard < 8 * SCAN_DIV + 16) begin
      @(negedge clock);
      guard++;
    end
    if (sb_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s scan_timeout: %0d entries left, expected 0", tag, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic do_write(int b, logic [15:0] v1, logic [15:0] v2);
    bus.wr_en   = 1'b1;
    bus.wr_bank = 3'(b);
    bus.wr_val1 = v1;
    bus.wr_val2 = v2;
    m_v1[b]     = v1;
    m_v2[b]     = v2;
    @(negedge clock);
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    int g;
    g = 0;
    repeat (3) @(negedge clock);
    while (bus.conv_busy && g < 4 * DATA_W) begin
      @(negedge clock);
      g++;
    end
    if (bus.conv_busy) begin
      vectors++;
      miscompares++;
      $display("FAIL %s busy_timeout: conv_busy still 1, expected 0", tag);
    end
    @(negedge clock);
  endtask

  task automatic measure_busy(output int n);
    int g;
    g = 0;
    n = 0;
    while (!bus.conv_busy && g < 10) begin
      @(negedge clock);
      g++;
    end
    while (bus.conv_busy && n < 200) begin
      n++;
      @(negedge clock);
    end
  endtask

  initial begin : monitor
    logic [7:0] last_sel;
    exp_t       e;
    last_sel = 8'hFF;
    forever begin
      @(negedge clock);
      if (bus.seg_sel !== last_sel && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check($sformatf("scan_sel_d%0d", e.d), 32'(bus.seg_sel), 32'(e.sel));
        check($sformatf("scan_seg_d%0d", e.d), 32'(bus.seg_out), 32'(e.seg));
      end
      last_sel = bus.seg_sel;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          n, r, b;
    logic [15:0] v1, v2;
    bus.wr_en    = 1'b0;
    bus.wr_bank  = '0;
    bus.wr_val1  = '0;
    bus.wr_val2  = '0;
    bus.view_sel = '0;
    bus.mode     = 1'b0;
    for (int i = 0; i < BANKS; i++) begin
      m_v1[i] = '0;
      m_v2[i] = '0;
    end
    m_view = 0;
    m_mode = 1'b0;
    reset  = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_sel", 32'(bus.seg_sel), 32'(exp_sel(0)));
    check("reset_seg", 32'(bus.seg_out), 32'(exp_seg(0)));
    check("reset_busy", 32'(bus.conv_busy), 32'd0);
    reset = 1'b0;

    check_cycles("idle", 40);
    arm_scan("idle_scan");

    do_write(0, 16'h1234, 16'hABCD);
    wait_idle("hex");
    arm_scan("hex_scan");
    do_write(3, 16'h5555, 16'h7777);
    repeat (4) begin
      check("nonview_busy", 32'(bus.conv_busy), 32'd0);
      @(negedge clock);
    end
    arm_scan("hex_nonview_scan");

    bus.mode = 1'b1;
    m_mode   = 1'b1;
    @(negedge clock);
    wait_idle("mode_dec");
    arm_scan("dec_4660");
    do_write(0, 16'hFFFF, 16'hABCD);
    measure_busy(n);
    check("busy_len_65535", 32'(n), 32'(DATA_W + 1));
    arm_scan("dec_65535");
    do_write(0, 16'd0, 16'hABCD);
    wait_idle("dec_zero");
    arm_scan("dec_zero_scan");

    // Retrigger: the display must hold the old value until 42 commits
    bus.wr_en   = 1'b1;
    bus.wr_bank = 3'd0;
    bus.wr_val1 = 16'd12345;
    bus.wr_val2 = m_v2[0];
    @(negedge clock);
    bus.wr_en = 1'b0;
    n = 0;
    r = 0;
    while (!bus.conv_busy && r < 10) begin
      @(negedge clock);
      r++;
    end
    while (bus.conv_busy && n < 200) begin
      n++;
      check_now("retrig_hold");
      if (n == 5) begin
        bus.wr_en   = 1'b1;
        bus.wr_val1 = 16'd42;
      end
      @(negedge clock);
      bus.wr_en = 1'b0;
    end
    check("busy_len_retrig", 32'(n), 32'(5 + 1 + DATA_W + 1));
    m_v1[0] = 16'd42;
    @(negedge clock);
    arm_scan("dec_42");

    do_write(2, 16'd999, 16'h0BAD);
    bus.view_sel = 3'd2;
    m_view       = 2;
    @(negedge clock);
    measure_busy(n);
    check("busy_len_view", 32'(n), 32'(DATA_W + 1));
    arm_scan("dec_999");

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        b  = ($urandom_range(0, 1) != 0) ? m_view : int'($urandom_range(0, BANKS - 1));
        v1 = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 999));
        v2 = 16'($urandom);
        do_write(b, v1, v2);
      end else if (r < 8) begin
        m_view       = int'($urandom_range(0, BANKS - 1));
        bus.view_sel = 3'(m_view);
        @(negedge clock);
      end else begin
        m_mode   = ~m_mode;
        bus.mode = m_mode;
        @(negedge clock);
      end
      wait_idle("rand");
      arm_scan($sformatf("rand%0d", it));
    end

    // Reset in the middle of a conversion
    bus.mode = 1'b1;
    m_mode   = 1'b1;
    @(negedge clock);
    wait_idle("pre_reset");
    do_write(m_view, 16'd54321, 16'h1357);
    r = 0;
    while (!bus.conv_busy && r < 10) begin
      @(negedge clock);
      r++;
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    for (int i = 0; i < BANKS; i++) begin
      m_v1[i] = '0;
      m_v2[i] = '0;
    end
    check("midreset_busy", 32'(bus.conv_busy), 32'd0);
    check("midreset_sel", 32'(bus.seg_sel), 32'(exp_sel(0)));
    check("midreset_seg", 32'(bus.seg_out), 32'(exp_seg(0)));
    reset = 1'b0;
    check_cycles("post_reset_dec", 12);
    check("post_reset_busy", 32'(bus.conv_busy), 32'd0);
    bus.mode = 1'b0;
    m_mode   = 1'b0;
    repeat (2) @(negedge clock);
    arm_scan("post_reset_hex");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
